btb_update_ctrl: RTL
====================

// Module: btb_update_ctrl
// PURPOSE
// - Serialises branch-resolution updates from WB into the BTB's single write port and sequences invalidate-all sweeps.
// - Sits between writeback (taken-branch events) and the BTB tag/valid/target arrays.
// - Buffers updates in a small FIFO while the BTB port is busy with ID-stage lookups.
// - Owns all BTB writes: line install on taken branch, line invalidate on reset/flush.
// PARAMETERS
// - DEPTH  4  update FIFO entries; power of 2, >=2
// - LINES  8  BTB sets swept on invalidate; power of 2; IDX_W = $clog2(LINES)
// PORTS
// - clk          in   1      clock; all state changes on posedge
// - reset        in   1      synchronous, active-high
// - upd_valid    in   1      WB presents a resolved branch this cycle
// - upd_taken    in   1      branch was taken (only taken branches install)
// - upd_pc       in   16     PC of the branch instruction
// - upd_target   in   16     resolved target address
// - upd_ready    out  1      controller can consume an update this cycle
// - flush        in   1      request invalidate-all of BTB
// - btb_we       out  1      install request: write btb_pc tag / btb_target at btb_index
// - btb_inval    out  1      invalidate request: clear all ways' valid bits at btb_index
// - btb_index    out  IDX_W  target set
// - btb_pc       out  16     tag source PC for install
// - btb_target   out  16     target for install
// - btb_ack      in   1      BTB accepted the current btb_we/btb_inval this cycle
// - busy         out  1      sweep in progress or FIFO non-empty
// BEHAVIOUR
// - Reset values: state=SWEEP, sweep ptr=0, FIFO empty, btb_we=0, btb_inval=1, btb_index=0, btb_pc=0, btb_target=0, upd_ready=0, busy=1.
// - btb_we and btb_inval are never high together. The request and its payload hold stable until the btb_ack cycle.
// - upd_ready = (state!=SWEEP) & !full & !flush. No same-cycle bypass: a full FIFO holds upd_ready=0 even in a dequeue cycle.
// - Handshake at upd_valid & upd_ready: taken -> enqueue {upd_pc, upd_target}; not taken -> consumed, no effect.
// - btb_index = pc[IDX_W:1] (halfword-aligned PC; bit 0 ignored).
// - FSM:
//   - SWEEP: btb_inval=1, btb_index=ptr. On btb_ack: if ptr==LINES-1 -> IDLE, ptr=0; else ptr++.
//   - IDLE: if FIFO non-empty -> ISSUE, with head loaded onto btb_* and btb_we=1 at the same edge.
//   - ISSUE: on btb_ack pop head. If FIFO still non-empty, present the next head in the following cycle with btb_we still 1; else -> IDLE.
// - Latency: an update accepted at edge N with FIFO empty in IDLE drives btb_we=1 after edge N+1; one install per ack thereafter.
// - flush (any state, highest priority):
//   - FIFO cleared, ptr=0, -> SWEEP.
//   - A same-cycle upd_valid is discarded.
//   - A same-cycle btb_ack completes its write; the sweep still re-covers every index.
// - reset mid-operation: same as the reset values; pending entries lost.
// - Wrap-around: FIFO pointers are IDX-of-DEPTH plus a wrap bit; full = ptrs equal with wrap bits differing.
// - Simultaneous enqueue and dequeue when not full: count unchanged, order preserved.
// CONFIGURATION
// - BTB_UPD_STATS_EN defined: adds output ports installs_cnt[15:0] and drops_cnt[15:0].
//   - installs_cnt increments on each btb_we & btb_ack.
//   - drops_cnt increments on each upd_valid & upd_taken & !upd_ready (including flush-discarded updates).
//   - Both saturate at 16'hFFFF and clear on reset only.
// - BTB_UPD_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset 1 cycle, btb_ack=1 -> btb_inval=1 for 8 cycles, index 0..7, then IDLE, upd_ready=1, busy=0.
// - In IDLE, upd {pc=16'h3004, tgt=16'h3010, taken=1} -> next cycle btb_we=1, btb_index=2, btb_pc=3004, btb_target=3010.
// - btb_ack=0, 4 taken updates -> upd_ready=0. Then ack each cycle -> 4 installs in enqueue order, with payload stable while unacked.
// - upd_valid=1, taken=0, pc=16'h3008 -> no btb_we, FIFO count unchanged.
// - 3 entries queued, then flush with upd_valid=1 -> FIFO empty, btb_inval sweep 0..7, the flushed-cycle update never installed.
// - With BTB_UPD_STATS_EN: 5 taken updates with FIFO full after 4 and ack=0 -> drops_cnt=1; after drain, installs_cnt=4.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: serialises taken-branch updates from writeback into the
// single BTB write port and sequences invalidate-all sweeps after reset/flush.
// Optional build macro BTB_UPD_STATS_EN adds saturating install/drop counters.
module btb_update_ctrl #(
    parameter  int DEPTH = 4,
    parameter  int LINES = 8,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             upd_valid,
    input  logic             upd_taken,
    input  logic [15:0]      upd_pc,
    input  logic [15:0]      upd_target,
    output logic             upd_ready,
    input  logic             flush,
    output logic             btb_we,
    output logic             btb_inval,
    output logic [IDX_W-1:0] btb_index,
    output logic [15:0]      btb_pc,
    output logic [15:0]      btb_target,
    input  logic             btb_ack,
    output logic             busy
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [15:0]      installs_cnt,
    output logic [15:0]      drops_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_SWEEP,
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_sweep_ptr, w_sweep_nxt;
    logic             r_btb_we, w_we_nxt;
    logic             r_btb_inval, w_inval_nxt;
    logic [IDX_W-1:0] r_btb_index, w_index_nxt;
    logic [15:0]      r_btb_pc, w_pc_nxt;
    logic [15:0]      r_btb_target, w_tgt_nxt;

    // FIFO: entry = {pc, target}; pointers carry an extra wrap bit
    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   w_rd_ptr_inc;
    logic             w_empty, w_full, w_push, w_pop, w_more;
    logic [31:0]      w_head, w_next_head;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                          (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign upd_ready    = (r_state != ST_SWEEP) && !w_full && !flush;
    assign w_push       = upd_valid && upd_ready && upd_taken;
    assign w_pop        = (r_state == ST_ISSUE) && btb_ack && !flush;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
    assign w_head       = r_mem[r_rd_ptr[PTR_W-1:0]];
    // An entry written this very cycle is not yet in r_mem, so forward it
    assign w_next_head  = (w_rd_ptr_inc == r_wr_ptr) ? {upd_pc, upd_target}
                                                     : r_mem[w_rd_ptr_inc[PTR_W-1:0]];
    assign w_more       = (w_rd_ptr_inc != r_wr_ptr) || w_push;

    // Update storage: written on accepted taken branches only
    // NOTE: storage array is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {upd_pc, upd_target};
        end
    end

    // FIFO pointers: cleared on reset or flush, otherwise advance on push/pop
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
        end
    end

    // FSM next-state and registered BTB request decode; flush overrides all
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_ptr;
        w_we_nxt    = r_btb_we;
        w_inval_nxt = r_btb_inval;
        w_index_nxt = r_btb_index;
        w_pc_nxt    = r_btb_pc;
        w_tgt_nxt   = r_btb_target;
        if (flush) begin
            w_state_nxt = ST_SWEEP;
            w_sweep_nxt = '0;
            w_we_nxt    = 1'b0;
            w_inval_nxt = 1'b1;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    if (btb_ack) begin
                        if (r_sweep_ptr == IDX_W'(LINES - 1)) begin
                            w_state_nxt = ST_IDLE;
                            w_sweep_nxt = '0;
                            w_inval_nxt = 1'b0;
                        end else begin
                            w_sweep_nxt = r_sweep_ptr + 1'b1;
                            w_index_nxt = r_sweep_ptr + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_state_nxt = ST_ISSUE;
                        w_we_nxt    = 1'b1;
                        w_pc_nxt    = w_head[31:16];
                        w_tgt_nxt   = w_head[15:0];
                        w_index_nxt = w_head[IDX_W+16:17];
                    end
                end
                ST_ISSUE: begin
                    if (btb_ack) begin
                        if (w_more) begin
                            w_pc_nxt    = w_next_head[31:16];
                            w_tgt_nxt   = w_next_head[15:0];
                            w_index_nxt = w_next_head[IDX_W+16:17];
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_we_nxt    = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_SWEEP;
                    w_sweep_nxt = '0;
                    w_we_nxt    = 1'b0;
                    w_inval_nxt = 1'b1;
                    w_index_nxt = '0;
                end
            endcase
        end
    end

    // State and BTB request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_SWEEP;
            r_sweep_ptr  <= '0;
            r_btb_we     <= 1'b0;
            r_btb_inval  <= 1'b1;
            r_btb_index  <= '0;
            r_btb_pc     <= '0;
            r_btb_target <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_ptr  <= w_sweep_nxt;
            r_btb_we     <= w_we_nxt;
            r_btb_inval  <= w_inval_nxt;
            r_btb_index  <= w_index_nxt;
            r_btb_pc     <= w_pc_nxt;
            r_btb_target <= w_tgt_nxt;
        end
    end

    assign btb_we     = r_btb_we;
    assign btb_inval  = r_btb_inval;
    assign btb_index  = r_btb_index;
    assign btb_pc     = r_btb_pc;
    assign btb_target = r_btb_target;
    assign busy       = (r_state == ST_SWEEP) || !w_empty;

`ifdef BTB_UPD_STATS_EN
    logic [15:0] r_installs_cnt, r_drops_cnt;

    // Saturating statistics: completed installs and refused taken updates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_installs_cnt <= '0;
            r_drops_cnt    <= '0;
        end else begin
            if (r_btb_we && btb_ack && (r_installs_cnt != 16'hFFFF))
                r_installs_cnt <= r_installs_cnt + 1'b1;
            if (upd_valid && upd_taken && !upd_ready && (r_drops_cnt != 16'hFFFF))
                r_drops_cnt <= r_drops_cnt + 1'b1;
        end
    end

    assign installs_cnt = r_installs_cnt;
    assign drops_cnt    = r_drops_cnt;
`endif

endmodule
